// File: rtl/rate_mult_gen_if.sv
// Bus bundle for rate_mult_gen: count/strobe enables, per-channel rates,
// cascade inputs and the pulse/enable outputs. Clock and reset stay outside.
interface rate_mult_gen_if #(
  parameter int unsigned W  = 6,
  parameter int unsigned CH = 1
);
  logic            V;     // count enable, active low
  logic            T;     // output strobe, active low
  logic [CH*W-1:0] Vnum;  // channel n rate in [n*W +: W]
  logic [CH-1:0]   CI;    // cascade in, active high
  logic [CH-1:0]   Z;     // registered pulse out
  logic [CH-1:0]   Y;     // Z | CI
  logic            P;     // count-enable out, active low

  // Driver side (testbench or upstream logic)
  modport master (
    output V, T, Vnum, CI,
    input  Z, Y, P
  );

  // Rate multiplier side
  modport slave (
    input  V, T, Vnum, CI,
    output Z, Y, P
  );
endinterface

// File: rtl/rate_mult_gen.sv
// Synchronous binary rate multiplier. A shared W-bit counter walks 0..2^W-1;
// at each enabled step the lowest clear counter bit k selects rate bit W-1-k,
// so rate bit j fires 2^j evenly spaced times per period. Channels share the
// counter and differ only in their rate word.
module rate_mult_gen #(
  parameter int unsigned W          = 6,
  parameter int unsigned CH         = 1,
  parameter int unsigned RATE_LATCH = 1
) (
  input logic           C,
  input logic           R,
  rate_mult_gen_if.slave bus
);

  logic [W-1:0]    cnt_q;
  logic [CH-1:0]   z_q;
  logic [CH*W-1:0] rate_eff;
  logic [W-1:0]    low_zero;
  logic [CH-1:0]   hit;
  logic            cnt_full;
  logic            count_en;

  assign cnt_full = &cnt_q;
  assign count_en = ~bus.V;

  // One-hot of the lowest clear bit; the carry of cnt+1 stops exactly there.
  // All ones rolls over to zero, giving no selected bit and hence no hit.
  assign low_zero = ~cnt_q & (cnt_q + 1'b1);

  // Rate source: frozen per period, or the live input word.
  if (RATE_LATCH != 0) begin : g_latch
    logic [CH*W-1:0] rate_q;

    // Capture the rate at reset and on the wrap step so a new value starts at cnt=0.
    always_ff @(posedge C) begin
      if (R) begin
        rate_q <= bus.Vnum;
      end else if (count_en && cnt_full) begin
        rate_q <= bus.Vnum;
      end
    end

    assign rate_eff = rate_q;
  end else begin : g_live
    assign rate_eff = bus.Vnum;
  end

  // Per-channel hit: low counter bit k pairs with high rate bit W-1-k.
  always_comb begin
    hit = '0;
    for (int n = 0; n < CH; n++) begin
      for (int i = 0; i < W; i++) begin
        if (low_zero[i] && rate_eff[n*W + (W-1-i)]) begin
          hit[n] = 1'b1;
        end
      end
    end
  end

  // Shared counter: advances while enabled, wraps naturally at 2^W.
  always_ff @(posedge C) begin
    if (R) begin
      cnt_q <= '0;
    end else if (count_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Pulse register: a hit gated by both enables becomes a one-cycle pulse.
  always_ff @(posedge C) begin
    if (R) begin
      z_q <= '0;
    end else begin
      z_q <= hit & {CH{count_en & ~bus.T}};
    end
  end

  // Outputs: P goes low only on the enabled terminal step so a downstream
  // stage advances once per upstream period; Y merges a cascaded stage.
  assign bus.Z = z_q;
  assign bus.Y = z_q | bus.CI;
  assign bus.P = ~(count_en & cnt_full);

endmodule

// File: tb/tb_rate_mult_gen.sv
// Randomised and directed bench for rate_mult_gen: a latched and a live
// two-channel instance run side by side against a period/phase model,
// followed by a two-stage cascade pulse-count check.
module tb_rate_mult_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rate_mult_gen_if #(.W(6), .CH(2)) bus_a ();
  rate_mult_gen_if #(.W(6), .CH(2)) bus_b ();
  rate_mult_gen_if #(.W(6), .CH(1)) bus_up ();
  rate_mult_gen_if #(.W(6), .CH(1)) bus_dn ();

  rate_mult_gen #(.W(6), .CH(2), .RATE_LATCH(1)) u_latch (.C(clk), .R(rst), .bus(bus_a));
  rate_mult_gen #(.W(6), .CH(2), .RATE_LATCH(0)) u_live (.C(clk), .R(rst), .bus(bus_b));
  rate_mult_gen #(.W(6), .CH(1), .RATE_LATCH(1)) u_up (.C(clk), .R(rst), .bus(bus_up));
  rate_mult_gen #(.W(6), .CH(1), .RATE_LATCH(1)) u_dn (.C(clk), .R(rst), .bus(bus_dn));

  // Downstream advances once per upstream period; its pulses merge into upstream Y.
  assign bus_dn.V  = bus_up.P;
  assign bus_up.CI = bus_dn.Y;

  int errors = 0;
  int checks = 0;

  // Reference state
  int       m_cnt;
  int       m_rq [2];
  logic [1:0] m_za;
  logic [1:0] m_zb;
  bit       m_valid = 1'b0;
  int       pa [2];
  int       pb [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Rate bit j owns 2^j evenly spaced slots: counts c with c mod 2^(6-j) == 2^(5-j)-1.
  function automatic bit mhit(input int c, input int rate);
    for (int j = 0; j < 6; j++) begin
      if (((rate >> j) & 1) == 1 && (c % (2 << (5 - j))) == ((1 << (5 - j)) - 1)) begin
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic clear_counts();
    pa[0] = 0; pa[1] = 0; pb[0] = 0; pb[1] = 0;
  endtask

  task automatic cyc(input bit r, input bit v, input bit t, input logic [11:0] vn,
                     input logic [1:0] ci);
    logic [1:0] ha;
    logic [1:0] hb;
    rst = r;
    bus_a.V = v; bus_a.T = t; bus_a.Vnum = vn; bus_a.CI = ci;
    bus_b.V = v; bus_b.T = t; bus_b.Vnum = vn; bus_b.CI = ci;
    #1;
    if (m_valid) begin
      check("p_latch", 32'(bus_a.P), (!v && m_cnt == 63) ? 32'd0 : 32'd1);
      check("p_live", 32'(bus_b.P), (!v && m_cnt == 63) ? 32'd0 : 32'd1);
      check("y_latch", 32'(bus_a.Y), 32'(m_za | ci));
      check("y_live", 32'(bus_b.Y), 32'(m_zb | ci));
    end
    for (int n = 0; n < 2; n++) begin
      ha[n] = mhit(m_cnt, m_rq[n]);
      hb[n] = mhit(m_cnt, int'(vn[n*6 +: 6]));
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_cnt   = 0;
      m_za    = 2'b00;
      m_zb    = 2'b00;
      m_rq[0] = int'(vn[5:0]);
      m_rq[1] = int'(vn[11:6]);
      m_valid = 1'b1;
    end else begin
      for (int n = 0; n < 2; n++) begin
        m_za[n] = !v && !t && ha[n];
        m_zb[n] = !v && !t && hb[n];
      end
      if (!v && m_cnt == 63) begin
        m_rq[0] = int'(vn[5:0]);
        m_rq[1] = int'(vn[11:6]);
      end
      if (!v) m_cnt = (m_cnt + 1) % 64;
    end
    check("z_latch", 32'(bus_a.Z), 32'(m_za));
    check("z_live", 32'(bus_b.Z), 32'(m_zb));
    for (int n = 0; n < 2; n++) begin
      pa[n] += int'(bus_a.Z[n]);
      pb[n] += int'(bus_b.Z[n]);
    end
  endtask

  task automatic period(input logic [11:0] vn);
    clear_counts();
    repeat (64) cyc(1'b0, 1'b0, 1'b0, vn, 2'($urandom));
  endtask

  initial begin
    logic [11:0] vn;
    bit r, v, t;
    int up_n, dn_n, mg_n, both_n;

    bus_up.V = 1'b1; bus_up.T = 1'b0; bus_up.Vnum = 6'd0;
    bus_dn.T = 1'b0; bus_dn.Vnum = 6'd0; bus_dn.CI = 1'b0;

    // Full and single-bit rates on the two channels
    cyc(1'b1, 1'b0, 1'b0, {6'd1, 6'd63}, 2'b00);
    period({6'd1, 6'd63});
    check("full_rate_latch", pa[0], 63);
    check("one_rate_latch", pa[1], 1);
    check("full_rate_live", pb[0], 63);
    check("one_rate_live", pb[1], 1);

    cyc(1'b1, 1'b0, 1'b0, 12'd0, 2'b00);
    period(12'd0);
    check("zero_rate_ch0", pa[0], 0);
    check("zero_rate_ch1", pa[1], 0);

    cyc(1'b1, 1'b0, 1'b0, {6'd0, 6'd32}, 2'b00);
    period({6'd0, 6'd32});
    check("rate32", pa[0], 32);

    cyc(1'b1, 1'b0, 1'b0, {6'd1, 6'h2A}, 2'b00);
    period({6'd1, 6'h2A});
    check("rate2a", pa[0], 42);
    check("rate2a_ch1", pa[1], 1);

    // Rate change at cnt=10: latched waits for the wrap, live follows at once
    cyc(1'b1, 1'b0, 1'b0, {6'd0, 6'd1}, 2'b00);
    clear_counts();
    for (int c = 0; c < 64; c++) begin
      vn = (c < 10) ? {6'd0, 6'd1} : {6'd0, 6'd63};
      cyc(1'b0, 1'b0, 1'b0, vn, 2'b00);
    end
    check("latch_old_period", pa[0], 1);
    check("live_mid_change", pb[0], 53);
    period({6'd0, 6'd63});
    check("latch_next_period", pa[0], 63);

    // Strobe off for cnt 0..15 drops those 16 hits; cnt=63 never hits anyway
    cyc(1'b1, 1'b0, 1'b0, {6'd0, 6'd63}, 2'b00);
    clear_counts();
    for (int c = 0; c < 64; c++) cyc(1'b0, 1'b0, (c < 16), {6'd0, 6'd63}, 2'b00);
    check("strobe_window", pa[0], 47);
    check("strobe_window_live", pb[0], 47);

    // Enable held off at cnt=7: no pulses while frozen
    cyc(1'b1, 1'b0, 1'b0, {6'd0, 6'd63}, 2'b00);
    repeat (7) cyc(1'b0, 1'b0, 1'b0, {6'd0, 6'd63}, 2'b00);
    clear_counts();
    repeat (5) cyc(1'b0, 1'b1, 1'b0, {6'd0, 6'd63}, 2'b01);
    check("hold_no_pulse", pa[0], 0);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, {6'd0, 6'd63}, 2'b00);

    // Reset at cnt=40 wins over enable and reloads the rate
    cyc(1'b1, 1'b0, 1'b0, {6'd0, 6'd63}, 2'b00);
    repeat (40) cyc(1'b0, 1'b0, 1'b0, {6'd0, 6'd63}, 2'b00);
    cyc(1'b1, 1'b0, 1'b0, {6'd0, 6'd1}, 2'b00);
    period({6'd0, 6'd1});
    check("reset_restart", pa[0], 1);

    // Random traffic
    vn = 12'($urandom);
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom % 64) == 0;
      v = ($urandom % 8) == 0;
      t = ($urandom % 8) == 0;
      if (($urandom % 16) == 0) vn = 12'($urandom);
      cyc(r, v, t, vn, 2'($urandom));
    end

    // Two-stage cascade, 12-bit rate 0x041
    bus_a.V = 1'b1; bus_b.V = 1'b1;
    bus_up.V = 1'b0; bus_up.Vnum = 6'd1; bus_dn.Vnum = 6'd1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    up_n = 0; dn_n = 0; mg_n = 0; both_n = 0;
    repeat (4096) begin
      @(posedge clk);
      #1;
      up_n   += int'(bus_up.Z);
      dn_n   += int'(bus_dn.Z);
      mg_n   += int'(bus_up.Y);
      both_n += int'(bus_up.Z & bus_dn.Z);
    end
    check("cascade_up", up_n, 64);
    check("cascade_dn", dn_n, 1);
    check("cascade_merged", mg_n, 65);
    check("cascade_collide", both_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
